// File: rtl/writebuffer_coalesce.sv
// Store buffer between the core data port and memory: in-order drain, byte
// coalescing into the youngest idle entry, load bypass on miss, fence drain.
module writebuffer_coalesce #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_valid,
  input  logic                         cpu_fence,
  input  logic [AW-1:0]                cpu_addr,
  input  logic [DW-1:0]                cpu_wdata,
  input  logic [DW/8-1:0]              cpu_wstrb,
  output logic [DW-1:0]                cpu_rdata,
  output logic                         cpu_ready,
  output logic                         mem_valid,
  output logic                         mem_fence,
  output logic [AW-1:0]                mem_addr,
  output logic [DW-1:0]                mem_wdata,
  output logic [DW/8-1:0]              mem_wstrb,
  input  logic [DW-1:0]                mem_rdata,
  input  logic                         mem_ready,
  output logic [1:0]                   dbg_state_o,
  output logic [$clog2(DEPTH+1)-1:0]   dbg_count_o
);
  localparam int SW  = DW / 8;
  localparam int OFF = $clog2(SW);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);

  // Handshakes: cpu_valid is a one-cycle request pulse answered by exactly one
  // cpu_ready pulse; mem_valid and all mem_* are held until the cycle in which
  // mem_ready is sampled high, and mem_ready is ignored while mem_valid is 0.
  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_LOAD, S_FENCE} state_t;
  typedef enum logic [1:0] {R_NONE, R_STORE, R_LOAD, R_FENCE} req_t;

  state_t          state_q;
  req_t            pend_kind_q;
  logic [AW-1:0]   pend_addr_q;
  logic [DW-1:0]   pend_wdata_q;
  logic [SW-1:0]   pend_wstrb_q;

  logic [AW-1:0]   ent_addr_q [DEPTH];
  logic [DW-1:0]   ent_data_q [DEPTH];
  logic [SW-1:0]   ent_strb_q [DEPTH];
  logic [DEPTH-1:0] ent_vld_q;
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q;

  logic            cpu_ready_q;
  logic [DW-1:0]   cpu_rdata_q;
  logic            mem_valid_q, mem_fence_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;
  logic [SW-1:0]   mem_wstrb_q;

  req_t            cur_kind;
  logic [AW-1:0]   cur_addr;
  logic [DW-1:0]   cur_wdata;
  logic [SW-1:0]   cur_wstrb;
  logic [AW-OFF-1:0] cur_word;
  logic [PW-1:0]   young;
  logic [DW-1:0]   merged, masked;
  logic            load_hit, load_go, fence_go, drain_go, head_busy;
  logic            pop, coalesce, enq, store_acc, load_done, fence_done;

  always_comb begin
    cur_kind  = pend_kind_q;
    cur_addr  = pend_addr_q;
    cur_wdata = pend_wdata_q;
    cur_wstrb = pend_wstrb_q;
    if (cpu_valid && pend_kind_q == R_NONE) begin
      cur_addr  = cpu_addr;
      cur_wdata = cpu_wdata;
      cur_wstrb = cpu_wstrb;
      if (cpu_fence)           cur_kind = R_FENCE;
      else if (cpu_wstrb != '0) cur_kind = R_STORE;
      else                     cur_kind = R_LOAD;
    end
    cur_word = cur_addr[AW-1:OFF];

    load_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld_q[i] && ent_addr_q[i][AW-1:OFF] == cur_word) load_hit = 1'b1;
    end

    load_go   = (state_q == S_IDLE) && (cur_kind == R_LOAD) && !load_hit;
    fence_go  = (state_q == S_IDLE) && (cur_kind == R_FENCE) && (count_q == '0);
    drain_go  = (state_q == S_IDLE) && !load_go && !fence_go && (count_q != '0);
    pop       = (state_q == S_DRAIN) && mem_ready;
    load_done = (state_q == S_LOAD) && mem_ready;
    fence_done = (state_q == S_FENCE) && mem_ready;

    // The head counts as in flight already in the cycle its drain is launched,
    // since mem_wdata captures the entry on that same edge.
    head_busy = (state_q == S_DRAIN) || drain_go;
    young     = tail_q - PW'(1);
    coalesce  = (cur_kind == R_STORE) && ent_vld_q[young] &&
                (ent_addr_q[young][AW-1:OFF] == cur_word) &&
                !(head_busy && young == head_q);
    enq       = (cur_kind == R_STORE) && !coalesce && ((count_q != CW'(DEPTH)) || pop);
    store_acc = coalesce || enq;

    merged = ent_data_q[young];
    masked = '0;
    for (int b = 0; b < SW; b++) begin
      if (cur_wstrb[b]) begin
        merged[8*b +: 8] = cur_wdata[8*b +: 8];
        masked[8*b +: 8] = cur_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pend_kind_q  <= R_NONE;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      pend_wstrb_q <= '0;
      ent_vld_q    <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      cpu_ready_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      mem_valid_q  <= 1'b0;
      mem_fence_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
    end else begin
      cpu_ready_q <= store_acc || load_done || fence_done;
      cpu_rdata_q <= load_done ? mem_rdata : '0;

      if (store_acc || load_done || fence_done) begin
        pend_kind_q <= R_NONE;
      end else begin
        pend_kind_q  <= cur_kind;
        pend_addr_q  <= cur_addr;
        pend_wdata_q <= cur_wdata;
        pend_wstrb_q <= cur_wstrb;
      end

      if (pop) begin
        ent_vld_q[head_q] <= 1'b0;
        head_q            <= head_q + PW'(1);
      end
      if (coalesce) begin
        ent_data_q[young] <= merged;
        ent_strb_q[young] <= ent_strb_q[young] | cur_wstrb;
      end
      // Placed after the pop so a full buffer can refill the freed slot.
      if (enq) begin
        ent_addr_q[tail_q] <= cur_addr;
        ent_data_q[tail_q] <= masked;
        ent_strb_q[tail_q] <= cur_wstrb;
        ent_vld_q[tail_q]  <= 1'b1;
        tail_q             <= tail_q + PW'(1);
      end
      count_q <= count_q + CW'(enq) - CW'(pop);

      case (state_q)
        S_IDLE: begin
          if (load_go) begin
            state_q     <= S_LOAD;
            mem_valid_q <= 1'b1;
            mem_fence_q <= 1'b0;
            mem_addr_q  <= cur_addr;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
          end else if (fence_go) begin
            state_q     <= S_FENCE;
            mem_valid_q <= 1'b1;
            mem_fence_q <= 1'b1;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
          end else if (drain_go) begin
            state_q     <= S_DRAIN;
            mem_valid_q <= 1'b1;
            mem_fence_q <= 1'b0;
            mem_addr_q  <= ent_addr_q[head_q];
            mem_wdata_q <= ent_data_q[head_q];
            mem_wstrb_q <= ent_strb_q[head_q];
          end
        end
        default: begin
          if (mem_ready) begin
            state_q     <= S_IDLE;
            mem_valid_q <= 1'b0;
            mem_fence_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
          end
        end
      endcase
    end
  end

  assign cpu_ready   = cpu_ready_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign mem_valid   = mem_valid_q;
  assign mem_fence   = mem_fence_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wstrb   = mem_wstrb_q;
  assign dbg_state_o = state_q;
  assign dbg_count_o = count_q;

endmodule

// File: tb/tb_writebuffer_coalesce.sv
// Directed bench for writebuffer_coalesce: expected memory transactions and
// core responses are queued by the stimulus and consumed by a monitor.
module tb_writebuffer_coalesce;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_valid = 1'b0, cpu_fence = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [3:0]  cpu_wstrb = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_valid, mem_fence;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit auto_rdy = 1'b0;
  int grant_n  = 0;

  logic [68:0] exp_mem_q[$];
  logic [31:0] exp_cpu_q[$];

  writebuffer_coalesce #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_valid(cpu_valid), .cpu_fence(cpu_fence), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .mem_valid(mem_valid), .mem_fence(mem_fence),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .dbg_state_o(dbg_state), .dbg_count_o(dbg_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory model: load data is a fixed tag in the upper half, address below.
  assign mem_rdata = 32'hC0DE_0000 | {16'h0, mem_addr[15:0]};

  always @(posedge clk) begin
    #1;
    if (mem_ready) mem_ready = 1'b0;
    else if (mem_valid && !rst && (auto_rdy || grant_n > 0)) begin
      mem_ready = 1'b1;
      if (!auto_rdy) grant_n--;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [68:0] txn(input logic f, input logic [31:0] a,
                                      input logic [31:0] d, input logic [3:0] s);
    logic [31:0] aa, dd;
    aa = f ? 32'h0 : a;
    dd = (s == 4'h0) ? 32'h0 : d;
    return {f, aa, dd, s};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    logic [68:0] got, exp;
    if (!rst && mem_valid && mem_ready) begin
      check("mem_txn_expected", 128'(exp_mem_q.size() != 0), 128'd1);
      if (exp_mem_q.size() != 0) begin
        exp = exp_mem_q.pop_front();
        got = txn(mem_fence, mem_addr, mem_wdata, mem_wstrb);
        check("mem_txn", 128'(got), 128'(exp));
      end
      if (mem_fence) check("fence_when_empty", 128'(dbg_count), 128'd0);
    end
    if (!rst && cpu_ready) begin
      check("cpu_rsp_expected", 128'(exp_cpu_q.size() != 0), 128'd1);
      if (exp_cpu_q.size() != 0) check("cpu_rdata", 128'(cpu_rdata), 128'(exp_cpu_q.pop_front()));
    end
  end

  // driver tasks
  task automatic issue(input logic f, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(posedge clk); #1;
    cpu_valid = 1'b1; cpu_fence = f; cpu_addr = a; cpu_wdata = d; cpu_wstrb = s;
    @(posedge clk); #1;
    cpu_valid = 1'b0; cpu_fence = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
  endtask

  task automatic wait_ready(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (cpu_ready) seen = 1'b1;
    end
    check(name, 128'(seen), 128'd1);
  endtask

  task automatic wait_count(input string name, input int value, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (dbg_count == 3'(value) && !mem_valid) seen = 1'b1;
    end
    check(name, 128'(seen), 128'd1);
  endtask

  task automatic store_basic(input string tag);
    auto_rdy = 1'b1;
    exp_mem_q.push_back(txn(1'b0, 32'h100, 32'hAABBCCDD, 4'hF));
    exp_cpu_q.push_back(32'h0);
    issue(1'b0, 32'h100, 32'hAABBCCDD, 4'hF);
    check({tag, "_ready_t1"}, 128'(cpu_ready), 128'd1);
    @(posedge clk); #1;
    check({tag, "_mvalid_t2"}, 128'(mem_valid), 128'd1);
    check({tag, "_maddr_t2"}, 128'(mem_addr), 128'h100);
    check({tag, "_mwdata_t2"}, 128'(mem_wdata), 128'hAABBCCDD);
    check({tag, "_mwstrb_t2"}, 128'(mem_wstrb), 128'hF);
    wait_count({tag, "_drained"}, 0, 20);
  endtask

  initial begin
    bit bad;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_mem_valid", 128'(mem_valid), 128'd0);
    check("rst_cpu_ready", 128'(cpu_ready), 128'd0);
    check("rst_count", 128'(dbg_count), 128'd0);
    check("rst_mem_wstrb", 128'(mem_wstrb), 128'd0);
    check("rst_state", 128'(dbg_state), 128'd0);

    // 1: single store, latency
    store_basic("s1");

    // 2: byte coalescing into the youngest non-issued entry
    auto_rdy = 1'b0; grant_n = 0;
    exp_mem_q.push_back(txn(1'b0, 32'h100, 32'h12345678, 4'hF));
    exp_mem_q.push_back(txn(1'b0, 32'h200, 32'h00330011, 4'h5));
    repeat (3) exp_cpu_q.push_back(32'h0);
    issue(1'b0, 32'h100, 32'h12345678, 4'hF); wait_ready("s2_st0", 5);
    issue(1'b0, 32'h200, 32'h00000011, 4'h1); wait_ready("s2_st1", 5);
    issue(1'b0, 32'h200, 32'h00330000, 4'h4); wait_ready("s2_st2", 5);
    check("s2_count", 128'(dbg_count), 128'd2);
    grant_n = 2;
    wait_count("s2_drained", 0, 30);

    // 3: full buffer holds the fifth store until a retire frees a slot
    for (int i = 0; i < 5; i++)
      exp_mem_q.push_back(txn(1'b0, 32'(i * 16), 32'h1000_0000 + 32'(i), 4'hF));
    for (int i = 0; i < 4; i++) begin
      exp_cpu_q.push_back(32'h0);
      issue(1'b0, 32'(i * 16), 32'h1000_0000 + 32'(i), 4'hF);
      wait_ready("s3_st", 5);
    end
    check("s3_count_full", 128'(dbg_count), 128'd4);
    issue(1'b0, 32'h40, 32'h1000_0004, 4'hF);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cpu_ready) bad = 1'b1;
    end
    check("s3_held_no_ready", 128'(bad), 128'd0);
    exp_cpu_q.push_back(32'h0);
    grant_n = 1;
    wait_ready("s3_fifth_ready", 6);
    check("s3_count_stays", 128'(dbg_count), 128'd4);
    grant_n = 4;
    wait_count("s3_drained", 0, 40);

    // 4: load miss bypasses queued store; load hit waits for the drain
    exp_mem_q.push_back(txn(1'b0, 32'h100, 32'h000000A1, 4'hF));
    exp_mem_q.push_back(txn(1'b0, 32'h300, 32'h0, 4'h0));
    exp_mem_q.push_back(txn(1'b0, 32'h104, 32'h000000B2, 4'hF));
    exp_cpu_q.push_back(32'h0);
    exp_cpu_q.push_back(32'h0);
    exp_cpu_q.push_back(32'hC0DE0300);
    issue(1'b0, 32'h100, 32'h000000A1, 4'hF); wait_ready("s4_st0", 5);
    issue(1'b0, 32'h104, 32'h000000B2, 4'hF); wait_ready("s4_st1", 5);
    issue(1'b0, 32'h300, 32'h0, 4'h0);
    grant_n = 3;
    wait_ready("s4_load_miss", 20);
    wait_count("s4_drained", 0, 20);
    exp_mem_q.push_back(txn(1'b0, 32'h104, 32'h0000C3C3, 4'hF));
    exp_mem_q.push_back(txn(1'b0, 32'h104, 32'h0, 4'h0));
    exp_cpu_q.push_back(32'h0);
    exp_cpu_q.push_back(32'hC0DE0104);
    issue(1'b0, 32'h104, 32'h0000C3C3, 4'hF); wait_ready("s4_st2", 5);
    issue(1'b0, 32'h104, 32'h0, 4'h0);
    grant_n = 2;
    wait_ready("s4_load_hit", 20);
    wait_count("s4_drained2", 0, 20);

    // 5: fence waits for an empty buffer
    for (int i = 0; i < 3; i++) begin
      exp_mem_q.push_back(txn(1'b0, 32'h40 + 32'(4 * i), 32'h5000_0000 + 32'(i), 4'hF));
      exp_cpu_q.push_back(32'h0);
      issue(1'b0, 32'h40 + 32'(4 * i), 32'h5000_0000 + 32'(i), 4'hF);
      wait_ready("s5_st", 5);
    end
    exp_mem_q.push_back(txn(1'b1, 32'h0, 32'h0, 4'h0));
    exp_cpu_q.push_back(32'h0);
    issue(1'b1, 32'h0, 32'h0, 4'h0);
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_fence || cpu_ready) bad = 1'b1;
    end
    check("s5_fence_held", 128'(bad), 128'd0);
    grant_n = 4;
    wait_ready("s5_fence_ready", 30);

    // 6: reset mid-transaction
    grant_n = 0;
    repeat (2) exp_cpu_q.push_back(32'h0);
    issue(1'b0, 32'h500, 32'h0000_0500, 4'hF); wait_ready("s6_st0", 5);
    issue(1'b0, 32'h504, 32'h0000_0504, 4'hF); wait_ready("s6_st1", 5);
    check("s6_inflight", 128'(mem_valid), 128'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("s6_mem_valid", 128'(mem_valid), 128'd0);
    check("s6_cpu_ready", 128'(cpu_ready), 128'd0);
    check("s6_count", 128'(dbg_count), 128'd0);
    store_basic("s6b");

    repeat (5) @(negedge clk);
    check("end_mem_q_empty", 128'(exp_mem_q.size()), 128'd0);
    check("end_cpu_q_empty", 128'(exp_cpu_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/writebuffer_coalesce.md
Name: writebuffer_coalesce

Overview:
Parametrised store buffer between the core data port and the data memory/cache port.
- Stores retire to the core after one cycle; buffered stores drain to memory in order.
- A new store to the same word as the youngest non-issued entry merges into it (byte coalescing).
- Loads that do not hit any buffered word bypass queued stores. Loads that hit wait until the matching entries drain.
- Fences drain the buffer fully, then issue a downstream fence.

Parameters:
- DEPTH, 4: entry count; power of two, ≥2.
- AW, 32: address width.
- DW, 32: data width; multiple of 8, ≥16. SW = DW/8 (strobe width); OFF = log2(SW).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cpu_valid  in  1  one-cycle request pulse; at most one outstanding until cpu_ready
- cpu_fence  in  1  request is a fence
- cpu_addr  in  AW  byte address; stores are word-contained
- cpu_wdata  in  DW  store data
- cpu_wstrb  in  SW  byte enables; 0 means load
- cpu_rdata  out  DW  load data; 0 for stores and fences
- cpu_ready  out  1  one-cycle completion pulse
- mem_valid  out  1  downstream request; held until mem_ready
- mem_fence  out  1  downstream request is a fence
- mem_addr  out  AW  downstream address
- mem_wdata  out  DW  downstream store data
- mem_wstrb  out  SW  downstream strobes; 0 for loads and fences
- mem_rdata  in  DW  downstream load data
- mem_ready  in  1  downstream completion, one cycle

Behaviour:
Clock and reset (already decided):
- One clock, clk; reset rst is synchronous and active-high.

Reset:
- All outputs are 0.
- Head/tail pointers are 0, count is 0, pending request is cleared.
- Entries are invalidated and the FSM goes to IDLE.
- Reset mid-transaction abandons the downstream request (mem_valid=0 next cycle). The pending core request is dropped with no cpu_ready.

Storage:
- Each entry holds {wstrb, addr, wdata}.
- count has width clog2(DEPTH+1). Pointers wrap from DEPTH-1 to 0.
- full = (count==DEPTH); empty = (count==0).

Request capture:
- On cpu_valid, the request is latched into a one-deep pending register: none, store, load or fence.

Store acceptance, evaluated each cycle with a pending store:
- Coalesce: the youngest entry has the same word address (addr[AW-1:OFF]) and is not the in-flight head. Bytes with a strobe set replace the entry's bytes; entry strobe |= new strobe. count is unchanged. Coalescing is allowed even when full.
- Otherwise, if not full (or an entry retires this same cycle), enqueue at tail; count+1.
- Otherwise, hold the store. Simultaneous retire and enqueue leaves count unchanged.
- cpu_ready=1 with cpu_rdata=0 in the cycle after acceptance.

Load handling:
- A load "hits" if any valid entry, including the in-flight one, matches its word address.
- A miss is issued in place of the next drain once no request is in flight. Load has priority over drain.
- A hit waits until no matching entry remains, then issues.
- cpu_rdata=mem_rdata captured and cpu_ready=1 in the cycle after mem_ready.

Fence handling:
- Waits for empty and no in-flight request, then issues mem_fence=1, mem_valid=1, mem_wstrb=0.
- cpu_ready pulses the cycle after mem_ready.

Downstream FSM (registered outputs):
- IDLE→LOAD when a load is eligible. IDLE→FENCE when a fence is eligible. IDLE→DRAIN when count>0.
- Priority: load, then fence, then drain.
- In DRAIN, LOAD and FENCE, mem_* are stable while mem_valid=1. On mem_ready, return to IDLE; in DRAIN also pop the head.
- Earliest next mem_valid is the cycle after mem_ready.
- The first store accepted in cycle T has mem_valid=1 at T+2.
- mem_ready while mem_valid=0 is ignored.

Test Plan:
1. DEPTH=4, DW=32, mem_ready=1 one cycle after each mem_valid. Store 0x100 / 0xAABBCCDD / 0xF in T → cpu_ready at T+1; mem_valid at T+2 with addr 0x100, wdata 0xAABBCCDD, wstrb 0xF; count returns to 0.
2. mem_ready=0. Store 0x100; then store 0x200 strb 0x1 data 0x11; then store 0x200 strb 0x4 data 0x00330000 → count=2. Release mem_ready: second drain shows addr 0x200, wdata 0x00330011, wstrb 0x5.
3. mem_ready=0. Four stores to 0x0, 0x10, 0x20, 0x30 → count=4; fifth store to 0x40 gets no cpu_ready. One mem_ready → 0x40 enqueued and cpu_ready the next cycle; count stays 4; drain order is 0x0, 0x10, 0x20, 0x30, 0x40.
4. Queue 0x100 (in flight) and 0x104, then load 0x300 → mem issues 0x100, then load 0x300, then 0x104. Load 0x104 with 0x104 queued → load issues only after 0x104 drains; cpu_rdata equals the returned mem_rdata.
5. Three stores queued, then fence → mem_fence=1 only after count=0 and the last mem_ready; cpu_ready=1 with cpu_rdata=0 the cycle after the fence mem_ready.
6. rst=1 for one cycle while mem_valid=1 with 2 entries queued → next cycle mem_valid=0, cpu_ready=0, count=0; a subsequent store behaves exactly as in scenario 1.
